// File: rtl/logic_unit_pkg.sv
// Shared definitions for the slice-serial logic unit: op codes and FSM encoding.
// No logic, so no latency.
// No flow control lives here.
package logic_unit_pkg;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_NAND  = 3'b011;
    localparam logic [2:0] OP_NOR   = 3'b100;
    localparam logic [2:0] OP_XNOR  = 3'b101;
    localparam logic [2:0] OP_ANDN  = 3'b110;
    localparam logic [2:0] OP_PASSA = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/logic_slice.sv
// SLICE-bit bitwise op unit, reused once per cycle by the serial datapath.
// Latency: purely combinational.
// Backpressure: none; the caller holds the operands.
module logic_slice
    import logic_unit_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    input  logic [2:0]       op,
    output logic [SLICE-1:0] y
);

    always_comb begin
        y = a_s;
        case (op)
            OP_AND:  y = a_s & b_s;
            OP_OR:   y = a_s | b_s;
            OP_XOR:  y = a_s ^ b_s;
            OP_NAND: y = ~(a_s & b_s);
            OP_NOR:  y = ~(a_s | b_s);
            OP_XNOR: y = ~(a_s ^ b_s);
            OP_ANDN: y = a_s & ~b_s;
            default: y = a_s;
        endcase
    end

endmodule

// File: rtl/logic_unit_serial.sv
// Slice-serial bitwise logic unit: one SLICE-bit slice per cycle, zero flag on the result.
// Latency: out_valid rises NUM_SLICES cycles after the accept edge.
// Backpressure: result held in DONE until out_ready; in_ready low whenever busy.
module logic_unit_serial
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int NUM_SLICES = WIDTH / SLICE;
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
        $error("logic_unit_serial: WIDTH must be a non-zero multiple of SLICE");
    end

    state_t                           state_q, state_d;
    logic [NUM_SLICES-1:0][SLICE-1:0] a_q, b_q, res_q;
    logic [2:0]                       op_q;
    logic [IDX_W-1:0]                 idx_q;
    logic                             zacc_q;
    logic [SLICE-1:0]                 y;
    logic                             last;

    assign last = (idx_q == IDX_W'(NUM_SLICES - 1));

    // Operands are stored as slice arrays so the per-cycle mux is a plain index.
    logic_slice #(.SLICE(SLICE)) u_slice (
        .a_s (a_q[idx_q]),
        .b_s (b_q[idx_q]),
        .op  (op_q),
        .y   (y)
    );

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = ~rst;
                if (in_valid) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (last) state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            zacc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && in_valid) begin
                a_q    <= a;
                b_q    <= b;
                op_q   <= op;
                idx_q  <= '0;
                zacc_q <= 1'b1;
            end
            if (state_q == ST_RUN) begin
                res_q[idx_q] <= y;
                zacc_q       <= zacc_q & (y == '0);
                if (!last) idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign result = res_q;
    assign zero   = (state_q == ST_DONE) & zacc_q;

endmodule

// File: tb/tb_logic_unit_serial.sv
// Scoreboard bench for logic_unit_serial: expectations queued at issue, compared at the output handshake.
module tb_logic_unit_serial;
    import logic_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_ready, out_valid, out_ready, zero;
    logic [31:0] a, b, result;
    logic [2:0]  op;

    logic        p8_in_valid, p8_in_ready, p8_out_valid, p8_zero;
    logic [7:0]  p8_a, p8_b, p8_result;
    logic [2:0]  p8_op;
    logic        p16_in_valid, p16_in_ready, p16_out_valid, p16_zero;
    logic [15:0] p16_a, p16_b, p16_result;
    logic [2:0]  p16_op;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    logic_unit_serial u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero)
    );

    logic_unit_serial #(.WIDTH(8), .SLICE(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(p8_in_valid), .in_ready(p8_in_ready),
        .a(p8_a), .b(p8_b), .op(p8_op), .out_valid(p8_out_valid), .out_ready(1'b1),
        .result(p8_result), .zero(p8_zero)
    );

    logic_unit_serial #(.WIDTH(16), .SLICE(2)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(p16_in_valid), .in_ready(p16_in_ready),
        .a(p16_a), .b(p16_b), .op(p16_op), .out_valid(p16_out_valid), .out_ready(1'b1),
        .result(p16_result), .zero(p16_zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x ^ y;
            3'd3:    return ~(x & y);
            3'd4:    return ~(x | y);
            3'd5:    return ~(x ^ y);
            3'd6:    return x & ~y;
            default: return x;
        endcase
    endfunction

    // Output side: every handshake retires the oldest expectation; reset abandons everything in flight.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            sb.delete();
        end else if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("zero", {31'd0, zero}, {31'd0, e.z});
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_wait", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_r);
        int   lat = 0;
        logic saw_rdy = 1'b0;
        wait_idle();
        in_valid = 1'b1;
        a = x; b = y; op = o;
        sb.push_back('{res: exp_r, z: (exp_r == 32'd0)});
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
        while (!out_valid && lat < 100) begin
            saw_rdy |= in_ready;
            lat++;
            @(posedge clk); #1;
        end
        chk("busy_in_ready", {31'd0, saw_rdy}, 32'd0);
        chk("latency", 32'(lat), 32'd8);
    endtask

    logic [31:0] sweep_exp [8];

    initial begin
        in_valid = 0; a = 0; b = 0; op = 0; out_ready = 1;
        p8_in_valid = 0; p8_a = 0; p8_b = 0; p8_op = 0;
        p16_in_valid = 0; p16_a = 0; p16_b = 0; p16_op = 0;
        sweep_exp = '{32'h05A005A0, 32'hAFF5AFF5, 32'hAA55AA55, 32'hFA5FFA5F,
                      32'h500A500A, 32'h55AA55AA, 32'hA005A005, 32'hA5A5A5A5};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        run_op(OP_AND, 32'hF0F01234, 32'hFF00FF0F, 32'hF0001204);
        run_op(OP_XOR, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000);
        run_op(OP_NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF);
        run_op(OP_ANDN, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000);

        // Stall the consumer while a competing request is offered.
        wait_idle();
        out_ready = 1'b0;
        run_op(OP_OR, 32'h12345678, 32'h0F0F0000, 32'h1F3F5678);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom; op = OP_XOR;
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_result", result, 32'h1F3F5678);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_in_ready", {31'd0, in_ready}, 32'd1);
        chk("hs_out_valid", {31'd0, out_valid}, 32'd0);
        run_op(OP_PASSA, 32'h13579BDF, 32'h0, 32'h13579BDF);

        // Abandon an op on its third RUN cycle.
        wait_idle();
        in_valid = 1'b1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; op = OP_AND;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_zero", {31'd0, zero}, 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        run_op(OP_NAND, 32'hFFFFFFFF, 32'h0000000F, 32'hFFFFFFF0);

        for (int i = 0; i < 8; i++)
            run_op(3'(i), 32'hA5A5A5A5, 32'h0FF00FF0, sweep_exp[i]);

        for (int i = 0; i < 6; i++) begin
            logic [2:0]  o;
            logic [31:0] x, y;
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            run_op(o, x, y, model(o, x, y));
        end

        begin
            int n = 0;
            while (sb.size() != 0 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            chk("sb_drain", 32'(sb.size()), 32'd0);
        end

        // Single-slice configuration: result one cycle after accept.
        p8_in_valid = 1'b1; p8_a = 8'hA5; p8_b = 8'h0F; p8_op = OP_OR;
        chk("w8_in_ready", {31'd0, p8_in_ready}, 32'd1);
        @(posedge clk); #1;
        p8_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("w8_out_valid", {31'd0, p8_out_valid}, 32'd1);
        chk("w8_result", {24'd0, p8_result}, 32'h000000AF);
        chk("w8_zero", {31'd0, p8_zero}, 32'd0);

        p16_in_valid = 1'b1; p16_a = 16'h0000; p16_b = 16'hFFFF; p16_op = OP_XNOR;
        chk("w16_in_ready", {31'd0, p16_in_ready}, 32'd1);
        @(posedge clk); #1;
        p16_in_valid = 1'b0;
        begin
            int lat = 0;
            while (!p16_out_valid && lat < 100) begin
                lat++;
                @(posedge clk); #1;
            end
            chk("w16_latency", 32'(lat), 32'd8);
        end
        chk("w16_result", {16'd0, p16_result}, 32'h00000000);
        chk("w16_zero", {31'd0, p16_zero}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
        $fatal(1);
    end

endmodule
